// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: decodes control flow, checks the fetch
// prediction, issues redirect and BTB update pulses, and squashes wrong-path cycles.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             stall,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  op1,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             carry_flag,
    input  logic             zero_flag,
    input  logic             negative_flag,
    input  logic             overflow_flag,
    input  logic             predicted_taken,
    input  logic [XLEN-1:0]  predicted_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             btb_upd_valid,
    output logic [XLEN-1:0]  btb_upd_pc,
    output logic [XLEN-1:0]  btb_upd_target,
    output logic             btb_upd_taken,
    output logic             flush_busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    // Counter needs at least one bit even when flushing is disabled.
    localparam int FC_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic [FC_W-1:0] r_fcnt, w_fcnt_nxt;

    logic             r_redirect_valid, r_btb_upd_valid, r_btb_upd_taken;
    logic [XLEN-1:0]  r_redirect_pc, r_btb_upd_pc, r_btb_upd_target;
    logic [CNT_W-1:0] r_branch_count, r_mispredict_count;

    logic            w_is_jal, w_is_jalr, w_is_br, w_is_cf;
    logic            w_br_taken, w_jump_en, w_mispred, w_accept;
    logic [XLEN-1:0] w_sum, w_target, w_corr;

    assign w_is_jal  = (opcode == OP_JAL);
    assign w_is_jalr = (opcode == OP_JALR);
    assign w_is_br   = (opcode == OP_BR);
    assign w_is_cf   = w_is_jal | w_is_jalr | w_is_br;

    // Flags come from rs1 - rs2; carry means unsigned borrow.
    always_comb begin
        w_br_taken = 1'b0;
        case (func3)
            3'b000:  w_br_taken = zero_flag;
            3'b001:  w_br_taken = ~zero_flag;
            3'b100:  w_br_taken = negative_flag ^ overflow_flag;
            3'b101:  w_br_taken = ~(negative_flag ^ overflow_flag);
            3'b110:  w_br_taken = carry_flag;
            3'b111:  w_br_taken = ~carry_flag;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_jump_en = w_is_jal | w_is_jalr | (w_is_br & w_br_taken);
    assign w_sum     = (w_is_jalr ? op1 : pc) + immediate;
    assign w_target  = w_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign w_mispred = w_is_cf &
                       ((w_jump_en != predicted_taken) |
                        (w_jump_en & predicted_taken & (predicted_target != w_target)));
    assign w_corr    = w_jump_en ? w_target : pc + XLEN'(4);
    assign w_accept  = valid_in & ~stall & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            S_IDLE: begin
                if (FLUSH_DEPTH > 0 && w_accept && w_mispred) begin
                    w_state_nxt = S_FLUSH;
                    w_fcnt_nxt  = FC_W'(FLUSH_DEPTH);
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    w_fcnt_nxt = r_fcnt - FC_W'(1);
                    if (r_fcnt == FC_W'(1)) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= '0;
            r_btb_upd_valid    <= 1'b0;
            r_btb_upd_pc       <= '0;
            r_btb_upd_target   <= '0;
            r_btb_upd_taken    <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_redirect_valid <= w_accept & w_mispred;
            r_btb_upd_valid  <= w_accept & w_is_cf;
            if (w_accept & w_mispred) begin
                r_redirect_pc <= w_corr;
                if (r_mispredict_count != '1)
                    r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
            if (w_accept & w_is_cf) begin
                r_btb_upd_pc     <= pc;
                r_btb_upd_target <= w_target;
                r_btb_upd_taken  <= w_jump_en;
                if (r_branch_count != '1)
                    r_branch_count <= r_branch_count + CNT_W'(1);
            end
        end
    end

    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign btb_upd_valid    = r_btb_upd_valid;
    assign btb_upd_pc       = r_btb_upd_pc;
    assign btb_upd_target   = r_btb_upd_target;
    assign btb_upd_taken    = r_btb_upd_taken;
    assign flush_busy       = (r_state == S_FLUSH);
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (default config and CNT_W=2/FLUSH_DEPTH=0)
// share stimulus and are compared every cycle against a comparison-level reference model.
module tb_branch_resolve_unit;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst, valid_in, stall;
    logic [31:0] pc, immediate, op1, predicted_target;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        carry_flag, zero_flag, negative_flag, overflow_flag, predicted_taken;

    logic        rv0, bv0, btk0, busy0, rv1, bv1, btk1, busy1;
    logic [31:0] rpc0, bpc0, btgt0, rpc1, bpc1, btgt1;
    logic [15:0] bc0, mc0;
    logic [1:0]  bc1, mc1;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(16), .FLUSH_DEPTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .pc(pc),
        .immediate(immediate), .op1(op1), .opcode(opcode), .func3(func3),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .negative_flag(negative_flag),
        .overflow_flag(overflow_flag), .predicted_taken(predicted_taken),
        .predicted_target(predicted_target), .redirect_valid(rv0), .redirect_pc(rpc0),
        .btb_upd_valid(bv0), .btb_upd_pc(bpc0), .btb_upd_target(btgt0),
        .btb_upd_taken(btk0), .flush_busy(busy0), .branch_count(bc0),
        .mispredict_count(mc0));

    branch_resolve_unit #(.XLEN(32), .CNT_W(2), .FLUSH_DEPTH(0)) u_dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .pc(pc),
        .immediate(immediate), .op1(op1), .opcode(opcode), .func3(func3),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .negative_flag(negative_flag),
        .overflow_flag(overflow_flag), .predicted_taken(predicted_taken),
        .predicted_target(predicted_target), .redirect_valid(rv1), .redirect_pc(rpc1),
        .btb_upd_valid(bv1), .btb_upd_pc(bpc1), .btb_upd_target(btgt1),
        .btb_upd_taken(btk1), .flush_busy(busy1), .branch_count(bc1),
        .mispredict_count(mc1));

    int checks = 0;
    int errors = 0;

    // Reference state per configuration: [0] depth 2 / 16-bit, [1] depth 0 / 2-bit.
    logic        m_rv[2], m_bv[2], m_btk[2];
    logic [31:0] m_rpc[2], m_bpc[2], m_btgt[2];
    int          m_fl[2], m_bc[2], m_mc[2];
    int          depth[2] = '{2, 0};
    int          cmax[2]  = '{65535, 3};
    logic [31:0] s_rs1, s_rs2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags are derived from real operands so the model can use plain comparisons.
    task automatic set_cmp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        s_rs1 = a; s_rs2 = b;
        d = a - b;
        zero_flag     = (d == 32'h0);
        carry_flag    = (a < b);
        negative_flag = d[31];
        overflow_flag = (a[31] != b[31]) && (d[31] != a[31]);
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [6:0] opc, input logic [31:0] p,
                                              input logic [31:0] imm, input logic [31:0] base);
        if (opc == OP_JALR) return (base + imm) & ~32'h1;
        return p + imm;
    endfunction

    task automatic model_step();
        logic cf, jmp, mis, busy, acc;
        logic [31:0] tgt;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rv[k] = 0; m_bv[k] = 0; m_btk[k] = 0;
                m_rpc[k] = 0; m_bpc[k] = 0; m_btgt[k] = 0;
                m_fl[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
            end else begin
                busy = (m_fl[k] > 0);
                acc  = valid_in && !stall && !busy;
                m_rv[k] = 0; m_bv[k] = 0;
                if (busy && !stall) m_fl[k]--;
                cf  = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BR);
                jmp = (opcode != OP_BR) ? 1'b1 : ref_taken(func3, s_rs1, s_rs2);
                tgt = ref_target(opcode, pc, immediate, op1);
                mis = (jmp != predicted_taken) || (jmp && predicted_taken && predicted_target != tgt);
                if (acc && cf) begin
                    m_bv[k] = 1; m_bpc[k] = pc; m_btgt[k] = tgt; m_btk[k] = jmp;
                    if (m_bc[k] < cmax[k]) m_bc[k]++;
                    if (mis) begin
                        m_rv[k] = 1;
                        m_rpc[k] = jmp ? tgt : pc + 32'd4;
                        if (m_mc[k] < cmax[k]) m_mc[k]++;
                        m_fl[k] = depth[k];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d0.redirect_valid", 64'(rv0),   64'(m_rv[0]));
        chk("d0.redirect_pc",    64'(rpc0),  64'(m_rpc[0]));
        chk("d0.btb_upd_valid",  64'(bv0),   64'(m_bv[0]));
        chk("d0.btb_upd_pc",     64'(bpc0),  64'(m_bpc[0]));
        chk("d0.btb_upd_target", 64'(btgt0), 64'(m_btgt[0]));
        chk("d0.btb_upd_taken",  64'(btk0),  64'(m_btk[0]));
        chk("d0.flush_busy",     64'(busy0), 64'(m_fl[0] > 0));
        chk("d0.branch_count",   64'(bc0),   64'(m_bc[0]));
        chk("d0.mispred_count",  64'(mc0),   64'(m_mc[0]));
        chk("d1.redirect_valid", 64'(rv1),   64'(m_rv[1]));
        chk("d1.redirect_pc",    64'(rpc1),  64'(m_rpc[1]));
        chk("d1.btb_upd_valid",  64'(bv1),   64'(m_bv[1]));
        chk("d1.btb_upd_pc",     64'(bpc1),  64'(m_bpc[1]));
        chk("d1.btb_upd_target", 64'(btgt1), 64'(m_btgt[1]));
        chk("d1.btb_upd_taken",  64'(btk1),  64'(m_btk[1]));
        chk("d1.flush_busy",     64'(busy1), 64'(m_fl[1] > 0));
        chk("d1.branch_count",   64'(bc1),   64'(m_bc[1]));
        chk("d1.mispred_count",  64'(mc1),   64'(m_mc[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] imm, input logic [31:0] base,
                         input logic pt, input logic [31:0] ptgt);
        valid_in = 1; opcode = opc; func3 = f3; pc = p; immediate = imm; op1 = base;
        predicted_taken = pt; predicted_target = ptgt;
    endtask

    initial begin
        int nb;
        logic [6:0] opcs[6];
        opcs[0] = OP_JAL; opcs[1] = OP_JALR; opcs[2] = OP_BR; opcs[3] = OP_BR;
        opcs[4] = 7'h33;  opcs[5] = 7'h13;
        rst = 1; valid_in = 0; stall = 0; pc = 0; immediate = 0; op1 = 0;
        opcode = 0; func3 = 0; predicted_taken = 0; predicted_target = 0;
        set_cmp(0, 0);
        for (int k = 0; k < 2; k++) begin
            m_fl[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
        end
        @(negedge clk);
        cyc(); cyc();
        chk("reset.redirect_pc", 64'(rpc0), 64'h0);
        chk("reset.flush_busy",  64'(busy0), 64'h0);
        rst = 0;

        // BEQ taken, predicted not taken
        set_cmp(32'd5, 32'd5);
        instr(OP_BR, 3'b000, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0);
        cyc(); valid_in = 0;
        chk("beq.redirect_valid", 64'(rv0),   64'h1);
        chk("beq.redirect_pc",    64'(rpc0),  64'h120);
        chk("beq.btb_taken",      64'(btk0),  64'h1);
        chk("beq.mispred_count",  64'(mc0),   64'h1);
        chk("beq.busy1",          64'(busy0), 64'h1);
        cyc(); chk("beq.busy2", 64'(busy0), 64'h1);
        cyc(); chk("beq.busy3", 64'(busy0), 64'h0);

        // JALR correctly predicted, target bit 0 cleared
        instr(OP_JALR, 3'b000, 32'h3000, 32'h4, 32'h2003, 1'b1, 32'h2006);
        cyc(); valid_in = 0;
        chk("jalr.redirect_valid", 64'(rv0),   64'h0);
        chk("jalr.btb_valid",      64'(bv0),   64'h1);
        chk("jalr.btb_target",     64'(btgt0), 64'h2006);
        chk("jalr.branch_count",   64'(bc0),   64'h2);
        chk("jalr.mispred_count",  64'(mc0),   64'h1);

        // JAL with wrong predicted target
        instr(OP_JAL, 3'b000, 32'h400, 32'h200, 32'h0, 1'b1, 32'h500);
        cyc(); valid_in = 0;
        chk("jal.redirect_valid", 64'(rv0),  64'h1);
        chk("jal.redirect_pc",    64'(rpc0), 64'h600);
        cyc(); cyc();

        // Mispredict, then a second mispredicting branch offered during a stalled flush
        set_cmp(32'd1, 32'd1);
        instr(OP_BR, 3'b000, 32'h800, 32'h40, 32'h0, 1'b0, 32'h0);
        cyc();
        nb = busy0 ? 1 : 0;
        set_cmp(32'd1, 32'd2);
        instr(OP_BR, 3'b000, 32'h900, 32'h40, 32'h0, 1'b1, 32'h940);
        stall = 1;
        repeat (3) begin cyc(); if (busy0) nb++; end
        stall = 0;
        repeat (2) begin cyc(); if (busy0) nb++; end
        valid_in = 0;
        for (int i = 0; i < 4 && busy0; i++) begin cyc(); if (busy0) nb++; end
        chk("flushstall.busy_cycles",   64'(nb),    64'd5);
        chk("flushstall.busy_done",     64'(busy0), 64'h0);
        chk("flushstall.mispred_count", 64'(mc0),   64'h3);
        chk("flushstall.branch_count",  64'(bc0),   64'h4);

        // pc+4 wraps to zero
        set_cmp(32'd7, 32'd7);
        instr(OP_BR, 3'b001, 32'hFFFF_FFFC, 32'h10, 32'h0, 1'b1, 32'h0C);
        cyc(); valid_in = 0;
        chk("wrap.redirect_valid", 64'(rv0),  64'h1);
        chk("wrap.redirect_pc",    64'(rpc0), 64'h0);
        chk("wrap.btb_taken",      64'(btk0), 64'h0);
        cyc(); cyc();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, tg;
            rst      = ($urandom_range(0, 99) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            opcode   = opcs[$urandom_range(0, 5)];
            func3    = 3'($urandom_range(0, 7));
            pc       = $urandom;
            immediate = ($urandom_range(0, 1) != 0) ? 32'($signed(12'($urandom))) : $urandom;
            op1      = $urandom;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            set_cmp(a, b);
            predicted_taken = 1'($urandom_range(0, 1));
            tg = ref_target(opcode, pc, immediate, op1);
            predicted_target = ($urandom_range(0, 1) != 0) ? tg : $urandom;
            cyc();
        end
        rst = 0; valid_in = 0; stall = 0;

        // Back-to-back mispredicts on the zero-depth instance saturate its 2-bit counter
        rst = 1; cyc(); rst = 0;
        set_cmp(32'd3, 32'd3);
        for (int i = 0; i < 5; i++) begin
            instr(OP_BR, 3'b000, 32'h1000 + 32'(i * 4), 32'h80, 32'h0, 1'b0, 32'h0);
            cyc();
            chk("sat.redirect_valid", 64'(rv1), 64'h1);
        end
        chk("sat.mispred_count", 64'(mc1), 64'h3);
        chk("sat.branch_count",  64'(bc1), 64'h3);
        chk("midflush.busy_before", 64'(busy0), 64'h1);

        // Reset while the default instance is flushing
        rst = 1; cyc();
        chk("midflush.redirect_valid", 64'(rv0),   64'h0);
        chk("midflush.redirect_pc",    64'(rpc0),  64'h0);
        chk("midflush.btb_valid",      64'(bv0),   64'h0);
        chk("midflush.btb_pc",         64'(bpc0),  64'h0);
        chk("midflush.btb_target",     64'(btgt0), 64'h0);
        chk("midflush.btb_taken",      64'(btk0),  64'h0);
        chk("midflush.flush_busy",     64'(busy0), 64'h0);
        chk("midflush.branch_count",   64'(bc0),   64'h0);
        chk("midflush.mispred_count",  64'(mc0),   64'h0);
        rst = 0; valid_in = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
